// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle radix-2 restoring divider for the execute stage (DIV / DIVU).
//   One operation is accepted through a valid/ready handshake. The divider then
//   produces one quotient bit per clock. The result, destination register
//   numbers and OV/S/Z flags are held until the consumer takes them.
//   Divide-by-zero and signed overflow (MIN / -1) bypass the iteration and
//   complete in one cycle.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush_i         pipeline flush, drops any operation in progress
//   in_valid_i      operation offered        in_ready_o   high only in IDLE
//   signed_i        1 = DIV, 0 = DIVU
//   dividend_i      reg2 value               divisor_i    reg1 value
//   dst_q_i/dst_r_i quotient / remainder destination register numbers
//   out_valid_o     result valid             out_ready_i  consumer takes result
//   quotient_o, remainder_o, dst_q_o, dst_r_o, we_q_o, we_r_o, ov_o, s_o, z_o
//   busy_o          high in any state except IDLE
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [REGW-1:0]  dst_q_i,
    input  logic [REGW-1:0]  dst_r_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic [REGW-1:0]  dst_q_o,
    output logic [REGW-1:0]  dst_r_o,
    output logic             we_q_o,
    output logic             we_r_o,
    output logic             ov_o,
    output logic             s_o,
    output logic             z_o,
    output logic             busy_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state_q, state_d;

    // Iteration datapath (no reset needed: always loaded on accept)
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    count_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [REGW-1:0]  dst_q_q;
    logic [REGW-1:0]  dst_r_q;

    // Magnitude of a two's-complement operand when signed mode is active.
    // MIN maps to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic en);
        return (en && v < 0) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic signed [WIDTH-1:0] v,
                                                  input logic en);
        return en ? -v : v;
    endfunction

    logic div_zero, sgn_ovf, fast, accept, last_step;
    logic [WIDTH:0]   shifted, trial;
    logic             trial_ok;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign div_zero  = (divisor_i == '0);
    assign sgn_ovf   = signed_i && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor_i);
    assign fast      = div_zero || sgn_ovf;
    assign accept    = (state_q == IDLE) && in_valid_i && !flush_i;
    assign last_step = (count_q == CW'(WIDTH-1));

    // Restoring step: shift next dividend bit into the partial remainder and
    // keep the difference only if it did not go negative.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr_q};
    assign trial_ok = !trial[WIDTH];

    assign q_fix = cond_neg(quo_q, neg_q_q);
    assign r_fix = cond_neg(rem_q, neg_r_q);

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid_i) state_d = fast ? DONE : CALC;
            CALC: if (last_step)  state_d = FIX;
            FIX:                  state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            neg_q_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_r_q <= signed_i && dividend_i[WIDTH-1];
            quo_q   <= mag(dividend_i, signed_i);
            dvsr_q  <= mag(divisor_i, signed_i);
            rem_q   <= '0;
            count_q <= '0;
            dst_q_q <= dst_q_i;
            dst_r_q <= dst_r_i;
        end else if (state_q == CALC) begin
            rem_q   <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q   <= {quo_q[WIDTH-2:0], trial_ok};
            count_q <= count_q + CW'(1);
        end
    end

    // Result registers: loaded only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient_o  <= '0;
            remainder_o <= '0;
            dst_q_o     <= '0;
            dst_r_o     <= '0;
            we_q_o      <= 1'b0;
            we_r_o      <= 1'b0;
            ov_o        <= 1'b0;
            s_o         <= 1'b0;
            z_o         <= 1'b0;
        end else if (accept && fast) begin
            quotient_o  <= div_zero ? '0 : dividend_i;
            remainder_o <= div_zero ? dividend_i : '0;
            dst_q_o     <= dst_q_i;
            dst_r_o     <= dst_r_i;
            we_q_o      <= (dst_q_i != '0);
            we_r_o      <= (dst_r_i != '0);
            ov_o        <= 1'b1;
            s_o         <= div_zero ? 1'b0 : dividend_i[WIDTH-1];
            z_o         <= div_zero ? 1'b1 : (dividend_i == '0);
        end else if (state_q == FIX && !flush_i) begin
            quotient_o  <= q_fix;
            remainder_o <= r_fix;
            dst_q_o     <= dst_q_q;
            dst_r_o     <= dst_r_q;
            we_q_o      <= (dst_q_q != '0);
            we_r_o      <= (dst_r_q != '0);
            ov_o        <= 1'b0;
            s_o         <= q_fix[WIDTH-1];
            z_o         <= (q_fix == '0);
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle radix-2 divider for the V850 execute stage. It takes over DIV/DIVU from the single-cycle execute path. It accepts one operation through a valid/ready handshake and iterates one quotient bit per clock. It holds the result, destination register numbers and OV/S/Z flags until the write-back/PSW logic accepts them. Divide-by-zero and signed overflow take a one-cycle fast path.

## Interface
- WIDTH, 32: operand/result width (≥ 4)
- REGW, 5: general-register index width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  synchronous cancel (pipeline flush); drops any operation in progress
- in_valid_i  in  1  operation offered
- in_ready_o  out  1  divider can accept (high only in IDLE)
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- dividend_i  in  WIDTH  reg2 value
- divisor_i  in  WIDTH  reg1 value
- dst_q_i  in  REGW  quotient destination (reg2 number)
- dst_r_i  in  REGW  remainder destination (reg3 number)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer takes result
- quotient_o  out  WIDTH
- remainder_o  out  WIDTH
- dst_q_o, dst_r_o  out  REGW  captured destinations
- we_q_o, we_r_o  out  1  write enables; 0 when the matching destination is r0
- ov_o, s_o, z_o  out  1  PSW OV/S/Z for this result
- busy_o  out  1  high in any state except IDLE

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready_o=1. On in_valid_i, latch mode and destinations.
  - Divisor == 0 → DONE with quotient=0, remainder=dividend, ov=1.
  - signed_i and dividend == 1<<(WIDTH-1) and divisor == all-ones → DONE with quotient=dividend, remainder=0, ov=1.
  - Otherwise latch |dividend| and |divisor| (signed mode; raw values in unsigned mode), clear partial remainder, count=0, go to CALC.
- CALC: one restoring step per cycle. Shift {rem, quo} left by 1; trial-subtract divisor from the WIDTH+1-bit rem. If the result is non-negative, keep it and set the quo LSB. count increments; after the step with count==WIDTH-1, go to FIX.
- FIX, signed mode only:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative. Division truncates toward zero; the remainder takes the dividend's sign.
  - ov=0. Go to DONE.
  - In unsigned mode FIX passes values through unchanged.
- DONE: out_valid_o=1 and all outputs are stable. s_o = quotient MSB; z_o = (quotient == 0), also on the fast paths. On out_ready_i go to IDLE. No new operation is accepted in the same cycle.
- flush_i: in any state, next state is IDLE and out_valid_o=0 next cycle; the result is lost. flush_i has priority over in_valid_i and out_ready_i.
- rst: same effect as flush_i and takes priority over it.
- Reset values: state IDLE, out_valid_o=0, in_ready_o=1, busy_o=0. quotient_o, remainder_o, dst_*_o, we_*_o, ov_o, s_o and z_o are all 0.
- Outputs are registered. They change only on DONE entry or reset.

## Timing
- Accept edge = the edge where in_valid_i && in_ready_o.
- Normal path: CALC occupies the next WIDTH cycles, FIX one cycle, and out_valid_o rises in the cycle WIDTH+2 after the accept cycle (cycle 34 for WIDTH=32).
- Fast path: out_valid_o is high in the cycle after the accept cycle.
- Back-to-back throughput: one operation per WIDTH+3 cycles (normal) or 2 cycles (fast), with out_ready_i held high.
- out_valid_o stays high, with outputs frozen, for as many cycles as out_ready_i stays low.
- in_ready_o is combinational from state only. It never depends on in_valid_i.

## Test plan
- Unsigned: dividend 100, divisor 7, signed_i=0, dst_q 3, dst_r 4 → out_valid in cycle 34: quotient 14, remainder 2, ov=0, s=0, z=0, we_q=we_r=1.
- Signed: dividend 7, divisor 0xFFFFFFFE (−2) → quotient 0xFFFFFFFD, remainder 1, s=1. Also dividend 0xFFFFFFF9 (−7), divisor 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Fast paths:
  - Divisor 0, dividend 0x1234 → valid next cycle: quotient 0, remainder 0x1234, ov=1, z=1.
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, ov=1, s=1.
  - The same operands with signed_i=0 take the normal path: quotient 0, remainder 0x80000000, ov=0, z=1.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid → outputs unchanged and in_ready_o=0 throughout. Then pulse out_ready_i → IDLE next cycle, and a new operation is accepted the following cycle.
- Flush/reset: assert flush_i at CALC cycle 10 → IDLE next cycle, no out_valid, and the next operation (50/5) returns quotient 10. Repeat with rst in DONE → all outputs return to reset values.
- r0 handling: dst_r_i=0, dst_q_i=5 → we_r_o=0, we_q_o=1, dst_q_o=5.
